// File: rtl/event_sched_pkg.sv
// Shared types and the round-robin pick helper for the event dispatch arbiter.
package event_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // The pick helper works on a fixed-width mask so it can serve any
    // arbiter with up to MAX_EVENTS sources.
    localparam int MAX_EVENTS = 32;
    localparam int PICK_W     = 5;

    // Returns the first set index in pend_mask scanning ptr, ptr+1, ... modulo num.
    // Returns ptr when nothing is set; callers only use the result when the mask is nonzero.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_EVENTS-1:0] pend_mask,
        input logic [PICK_W-1:0]     ptr,
        input int unsigned           num
    );
        logic            found;
        logic [PICK_W:0] idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < MAX_EVENTS; k++) begin
            idx = {1'b0, ptr} + (PICK_W+1)'(k);
            if (idx >= (PICK_W+1)'(num)) begin
                idx = idx - (PICK_W+1)'(num);
            end
            if (!found && (k < int'(num)) && pend_mask[idx[PICK_W-1:0]]) begin
                rr_pick = idx[PICK_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/event_pend_counter.sv
// One source's pending-event counter: saturating up/down count plus sticky overflow.
module event_pend_counter
    import event_sched_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic ovf_clr,
    output logic nonzero,
    output logic nonzero_next,
    output logic ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_set;
    logic             ovf_d;

    // Next count: simultaneous inc and dec cancel; an increment at max is lost and flagged.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) begin
                ovf_set = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Clear wins over a same-cycle overflow so the flag never re-arms on the clearing cycle.
        ovf_d = ovf_clr ? 1'b0 : (ovf | ovf_set);
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf   <= ovf_d;
        end
    end

    assign nonzero      = (cnt_q != '0);
    assign nonzero_next = (cnt_d != '0);

endmodule

// File: rtl/event_dispatch_arbiter.sv
// Collects event pulses into per-source counters and hands them out one at a
// time over valid/ready, round-robin across sources.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | nothing offered; pick next pending source from rr_ptr onward
//  OFFER | disp_id_o offered and frozen until the consumer takes it
module event_dispatch_arbiter
    import event_sched_pkg::*;
#(
    parameter  int NUM_EVENTS = 3,
    parameter  int CNT_W      = 4,
    localparam int ID_W       = $clog2(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_EVENTS-1:0] ev_trig_i,
    output logic                  disp_valid_o,
    output logic [ID_W-1:0]       disp_id_o,
    input  logic                  disp_ready_i,
    output logic                  pend_any_o,
    output logic [NUM_EVENTS-1:0] ovf_o,
    input  logic                  ovf_clr_i
);

    state_e                state_q;
    state_e                state_d;
    logic                  valid_d;
    logic [ID_W-1:0]       id_d;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]       rr_ptr_d;
    logic [ID_W:0]         id_inc;
    logic                  pend_any_d;
    logic                  xfer;
    logic [NUM_EVENTS-1:0] pend_nz;
    logic [NUM_EVENTS-1:0] pend_nz_next;
    logic [NUM_EVENTS-1:0] dec_vec;

    assign xfer = disp_valid_o && disp_ready_i;

    genvar i;
    generate
        for (i = 0; i < NUM_EVENTS; i++) begin : g_pend
            assign dec_vec[i] = xfer && (disp_id_o == ID_W'(i));

            event_pend_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk          (clk),
                .rst_n        (rst_n),
                .inc          (ev_trig_i[i]),
                .dec          (dec_vec[i]),
                .ovf_clr      (ovf_clr_i),
                .nonzero      (pend_nz[i]),
                .nonzero_next (pend_nz_next[i]),
                .ovf          (ovf_o[i])
            );
        end
    endgenerate

    // pend_any_o is registered from post-update counter values.
    assign pend_any_d = |pend_nz_next;

    // Next state, offer registers and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        valid_d  = disp_valid_o;
        id_d     = disp_id_o;
        rr_ptr_d = rr_ptr_q;
        // Wrap in ID_W+1 bits so non-power-of-2 source counts work.
        id_inc   = {1'b0, disp_id_o} + (ID_W+1)'(1);
        if (id_inc >= (ID_W+1)'(NUM_EVENTS)) begin
            id_inc = '0;
        end
        case (state_q)
            IDLE: begin
                if (|pend_nz) begin
                    id_d    = ID_W'(rr_pick(MAX_EVENTS'(pend_nz), PICK_W'(rr_ptr_q), NUM_EVENTS));
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (disp_ready_i) begin
                    rr_ptr_d = ID_W'(id_inc);
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, offer outputs, pointer and pend_any registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            disp_valid_o <= 1'b0;
            disp_id_o    <= '0;
            rr_ptr_q     <= '0;
            pend_any_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_valid_o <= valid_d;
            disp_id_o    <= id_d;
            rr_ptr_q     <= rr_ptr_d;
            pend_any_o   <= pend_any_d;
        end
    end

endmodule

// File: tb/tb_event_dispatch_arbiter.sv
// Directed bench for event_dispatch_arbiter with a dispatch-order scoreboard.
module tb_event_dispatch_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ev_trig;
    logic       disp_valid;
    logic [1:0] disp_id;
    logic       disp_ready;
    logic       pend_any;
    logic [2:0] ovf;
    logic       ovf_clr;

    int         total = 0;
    int         bad = 0;
    int         xfer_cnt = 0;
    int         base;
    logic [1:0] exp_q[$];
    logic [1:0] exp_id;

    event_dispatch_arbiter #(
        .NUM_EVENTS (3),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ev_trig_i    (ev_trig),
        .disp_valid_o (disp_valid),
        .disp_id_o    (disp_id),
        .disp_ready_i (disp_ready),
        .pend_any_o   (pend_any),
        .ovf_o        (ovf),
        .ovf_clr_i    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && !disp_valid) break;
            tick();
        end
        check("drain_left", exp_q.size(), 0);
        tick();
        tick();
    endtask

    // Scoreboard: every transfer must match the next expected id.
    always @(negedge clk) begin
        if (rst_n && disp_valid && disp_ready) begin
            xfer_cnt++;
            check("sb_expected_any", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_id = exp_q.pop_front();
                check("sb_id", disp_id, exp_id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        ev_trig    = 3'b000;
        disp_ready = 1'b0;
        ovf_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_valid", disp_valid, 0);
        check("rst_id", disp_id, 0);
        check("rst_pend", pend_any, 0);
        check("rst_ovf", ovf, 0);
        tick();

        // 1: single trigger on source 0
        disp_ready = 1'b1;
        ev_trig = 3'b001;
        exp_q.push_back(2'd0);
        tick();
        ev_trig = 3'b000;
        check("t1_valid_t1", disp_valid, 0);
        check("t1_pend_t1", pend_any, 1);
        tick();
        check("t1_valid_t2", disp_valid, 1);
        check("t1_id_t2", disp_id, 0);
        tick();
        check("t1_valid_t3", disp_valid, 0);
        check("t1_pend_t3", pend_any, 0);
        drain(10);

        // 2: A, B, C one cycle apart
        base = xfer_cnt;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        ev_trig = 3'b001; tick();
        ev_trig = 3'b010; tick();
        ev_trig = 3'b100; tick();
        ev_trig = 3'b000;
        drain(40);
        check("t2_xfers", xfer_cnt - base, 3);
        check("t2_ovf", ovf, 0);

        // 3: all three at once, transfers two cycles apart
        base = xfer_cnt;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        ev_trig = 3'b111; tick();
        ev_trig = 3'b000;
        check("t3_c1_valid", disp_valid, 0);
        tick();
        check("t3_c2_valid", disp_valid, 1);
        check("t3_c2_id", disp_id, 0);
        tick();
        check("t3_c3_valid", disp_valid, 0);
        tick();
        check("t3_c4_valid", disp_valid, 1);
        check("t3_c4_id", disp_id, 1);
        tick();
        check("t3_c5_valid", disp_valid, 0);
        tick();
        check("t3_c6_valid", disp_valid, 1);
        check("t3_c6_id", disp_id, 2);
        tick();
        check("t3_c7_valid", disp_valid, 0);
        check("t3_c7_pend", pend_any, 0);
        check("t3_xfers", xfer_cnt - base, 3);
        // rr_ptr wrapped to 0, so source 0 goes before source 2
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        ev_trig = 3'b101; tick();
        ev_trig = 3'b000;
        drain(20);

        // 4: backpressure and saturation on source 1
        disp_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            ev_trig = 3'b010;
            tick();
            if (k >= 1) begin
                check("t4_hold_valid", disp_valid, 1);
                check("t4_hold_id", disp_id, 1);
            end
        end
        ev_trig = 3'b000;
        check("t4_ovf_set", ovf, 3'b010);
        base = xfer_cnt;
        for (int k = 0; k < 15; k++) exp_q.push_back(2'd1);
        disp_ready = 1'b1;
        drain(80);
        check("t4_xfers", xfer_cnt - base, 15);
        check("t4_pend_empty", pend_any, 0);
        check("t4_ovf_sticky", ovf, 3'b010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", ovf, 0);

        // 5: fairness, source 0 every cycle, source 2 once
        base = xfer_cnt;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        for (int k = 0; k < 4; k++) exp_q.push_back(2'd0);
        ev_trig = 3'b001; tick();
        ev_trig = 3'b001; tick();
        ev_trig = 3'b001; tick();
        ev_trig = 3'b101; tick();
        ev_trig = 3'b001; tick();
        ev_trig = 3'b001; tick();
        ev_trig = 3'b000;
        drain(60);
        check("t5_xfers", xfer_cnt - base, 7);

        // 6: reset while offering with counts 3/0/2
        disp_ready = 1'b0;
        ev_trig = 3'b101; tick();
        ev_trig = 3'b101; tick();
        ev_trig = 3'b001; tick();
        ev_trig = 3'b000;
        check("t6_offer_valid", disp_valid, 1);
        check("t6_offer_pend", pend_any, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", disp_valid, 0);
        check("t6_async_pend", pend_any, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        base = xfer_cnt;
        disp_ready = 1'b1;
        repeat (6) tick();
        check("t6_post_valid", disp_valid, 0);
        check("t6_post_pend", pend_any, 0);
        check("t6_post_xfers", xfer_cnt - base, 0);
        check("end_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
